uart_rx_buffered: RTL and testbench

UART receive front end for `main`: samples the asynchronous `rx_serial` line, decodes 8N1 frames at `CLKS_PER_BIT` clocks per bit, and queues received bytes in a small first-word-fall-through FIFO. It feeds the mode-3 (UART-driven) message path with a valid/ready byte stream. It also reports framing errors and FIFO overflow.

---
 rtl/uart_rx_buffered.sv | 125 ++++++++++++
 tb/tb_uart_rx_buffered.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Ports: in_clk/in_reset (sync, active-high); rx_serial async line in; in_ready pops the head;
//        out_data/out_valid/out_count expose the FIFO head and occupancy; out_frame_err and
//        out_overflow are single-cycle error pulses one cycle after the stop-bit sample.
module uart_rx_buffered #(
  parameter int CLKS_PER_BIT = 640,
  parameter int DEPTH        = 16
) (
  input  logic                     in_clk,
  input  logic                     in_reset,
  input  logic                     rx_serial,
  input  logic                     in_ready,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   out_count,
  output logic                     out_frame_err,
  output logic                     out_overflow
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_t;

  state_t          state, state_nxt;
  logic            sync1, rxs;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            bit_smp, stop_smp;

  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic            pop, push, full;

  assign out_valid = (out_count != '0);
  assign out_data  = mem[rd_ptr];
  assign full      = (out_count == FULL_CNT);
  assign pop       = out_valid && in_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still take the byte.
  assign push      = stop_smp && rxs && (!full || pop);

  always_comb begin
    state_nxt = state;
    bit_smp   = 1'b0;
    stop_smp  = 1'b0;
    case (state)
      IDLE:    if (!rxs) state_nxt = START;
      // Mid-start re-check: a line that is high again was only a glitch.
      START:   if (cnt == HALF_LAST) state_nxt = rxs ? IDLE : DATA;
      DATA: begin
        if (cnt == BIT_LAST) begin
          bit_smp = 1'b1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          stop_smp  = 1'b1;
          state_nxt = rxs ? IDLE : RECOVER;
        end
      end
      // Hold off until the line returns high so a break is not seen as a new start.
      RECOVER: if (rxs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      sync1         <= 1'b1;
      rxs           <= 1'b1;
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      out_frame_err <= 1'b0;
      out_overflow  <= 1'b0;
    end else begin
      sync1 <= rx_serial;
      rxs   <= sync1;
      state <= state_nxt;
      if (state_nxt != state || bit_smp)
        cnt <= '0;
      else if (state == START || state == DATA || state == STOP)
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
      if (state == START)
        bit_idx <= '0;
      if (bit_smp) begin
        shreg   <= {rxs, shreg[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      out_frame_err <= stop_smp && !rxs;
      out_overflow  <= stop_smp && rxs && full && !pop;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      out_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   out_count <= out_count + 1'b1;
        2'b01:   out_count <= out_count - 1'b1;
        default: out_count <= out_count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered: directed bench for uart_rx_buffered with a byte scoreboard.
// Ports: none; drives the DUT with a short bit period so the whole run stays small.
// Expected bytes are queued when sent and compared as the DUT hands them out.
module tb_uart_rx_buffered;

  localparam int CPB   = 16;
  localparam int DEPTH = 16;

  logic       in_clk = 1'b0;
  logic       in_reset;
  logic       rx_serial;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic [$clog2(DEPTH):0] out_count;
  logic       out_frame_err;
  logic       out_overflow;

  int passed = 0;
  int total  = 0;
  int ovf_cnt = 0;
  int fe_cnt  = 0;
  logic [7:0] exp_q[$];

  uart_rx_buffered #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .in_clk(in_clk), .in_reset(in_reset), .rx_serial(rx_serial), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_count(out_count),
    .out_frame_err(out_frame_err), .out_overflow(out_overflow)
  );

  always #5 in_clk = ~in_clk;

  // Counts high cycles of each pulse, so a delta of 1 also proves a one-cycle width.
  always @(negedge in_clk) begin
    if (out_overflow)  ovf_cnt++;
    if (out_frame_err) fe_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic pop_one();
    logic [7:0] e;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else e = 8'hxx;
    check("pop_valid", 32'(out_valid), 32'd1);
    check("pop_data", 32'(out_data), 32'(e));
    in_ready = 1'b1;
    @(negedge in_clk);
    in_ready = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 8; i++) begin
      if (!out_valid) break;
      pop_one();
    end
    check("drain_valid_low", 32'(out_valid), 32'd0);
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Drives one frame starting at a negedge. With pop_at_stop the head is popped in
  // exactly the cycle whose closing edge samples the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_len,
                            input bit pop_at_stop);
    logic [7:0] head;
    logic [$clog2(DEPTH):0] cnt_before;
    rx_serial = 1'b0;
    repeat (CPB) @(negedge in_clk);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      repeat (CPB) @(negedge in_clk);
    end
    rx_serial = stop_val;
    if (pop_at_stop) begin
      repeat (CPB / 2 + 2) @(negedge in_clk);
      head = exp_q.pop_front();
      check("stop_pop_data", 32'(out_data), 32'(head));
      cnt_before = out_count;
      in_ready = 1'b1;
      @(negedge in_clk);
      in_ready = 1'b0;
      check("pushpop_count_same", 32'(out_count), 32'(cnt_before));
      repeat (CPB - CPB / 2 - 3) @(negedge in_clk);
    end else begin
      repeat (CPB * stop_len) @(negedge in_clk);
    end
    rx_serial = 1'b1;
  endtask

  initial begin
    int lat;
    int ovf0, fe0;
    logic [7:0] pat [3];
    pat[0] = 8'h3F; pat[1] = 8'h03; pat[2] = 8'h33;

    in_reset = 1'b1; rx_serial = 1'b1; in_ready = 1'b0;
    repeat (3) @(negedge in_clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(out_count), 32'd0);
    check("rst_data", 32'(out_data), 32'h00);
    check("rst_frame_err", 32'(out_frame_err), 32'd0);
    check("rst_overflow", 32'(out_overflow), 32'd0);
    in_reset = 1'b0;
    repeat (4) @(negedge in_clk);

    // Single byte with latency measured from the start edge.
    exp_q.push_back(8'h3F);
    lat = 0;
    fork
      send_frame(8'h3F, 1'b1, 1, 1'b0);
      begin
        while (!out_valid && lat < 4000) begin
          @(negedge in_clk);
          lat++;
        end
      end
    join
    check_rng("first_latency", lat, (CPB * 19) / 2 + 1, (CPB * 19) / 2 + 5);
    check("single_count", 32'(out_count), 32'd1);
    pop_one();
    check("single_valid_after_pop", 32'(out_valid), 32'd0);
    check("single_count_after_pop", 32'(out_count), 32'd0);

    // Fill past capacity with back-to-back frames.
    ovf0 = ovf_cnt; fe0 = fe_cnt;
    for (int i = 0; i < 18; i++) begin
      if (i < DEPTH) exp_q.push_back(pat[i % 3]);
      send_frame(pat[i % 3], 1'b1, 1, 1'b0);
    end
    repeat (4) @(negedge in_clk);
    check("fill_count", 32'(out_count), 32'(DEPTH));
    check("fill_overflows", 32'(ovf_cnt - ovf0), 32'd2);
    check("fill_no_frame_err", 32'(fe_cnt - fe0), 32'd0);
    drain();

    // Short low glitch must not produce a byte or any pulse.
    ovf0 = ovf_cnt; fe0 = fe_cnt;
    rx_serial = 1'b0;
    repeat (CPB / 2 - 4) @(negedge in_clk);
    rx_serial = 1'b1;
    repeat (12 * CPB) @(negedge in_clk);
    check("glitch_count", 32'(out_count), 32'd0);
    check("glitch_no_err", 32'(fe_cnt - fe0), 32'd0);
    check("glitch_no_ovf", 32'(ovf_cnt - ovf0), 32'd0);

    // Framing error, line break, then a good byte.
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0, 2, 1'b0);
    repeat (CPB) @(negedge in_clk);
    check("frame_err_pulse", 32'(fe_cnt - fe0), 32'd1);
    check("frame_err_no_write", 32'(out_count), 32'd0);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1, 1'b0);
    repeat (4) @(negedge in_clk);
    check("after_err_count", 32'(out_count), 32'd1);
    check("after_err_single_pulse", 32'(fe_cnt - fe0), 32'd1);
    drain();

    // Full FIFO with a pop landing on the stop-sample cycle.
    ovf0 = ovf_cnt;
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(8'(i * 29 + 7));
      send_frame(8'(i * 29 + 7), 1'b1, 1, 1'b0);
    end
    repeat (4) @(negedge in_clk);
    check("full_count", 32'(out_count), 32'(DEPTH));
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1, 1'b1);
    repeat (4) @(negedge in_clk);
    check("full_pop_no_ovf", 32'(ovf_cnt - ovf0), 32'd0);
    check("full_pop_count", 32'(out_count), 32'(DEPTH));
    drain();

    // Reset during data bit 4 with two bytes queued.
    exp_q.push_back(8'h33); send_frame(8'h33, 1'b1, 1, 1'b0);
    exp_q.push_back(8'h03); send_frame(8'h03, 1'b1, 1, 1'b0);
    repeat (4) @(negedge in_clk);
    check("pre_reset_count", 32'(out_count), 32'd2);
    fork
      send_frame(8'hFC, 1'b1, 1, 1'b0);
      begin
        repeat (5 * CPB + 2) @(negedge in_clk);
        in_reset = 1'b1;
        @(negedge in_clk);
        in_reset = 1'b0;
        exp_q.delete();
        check("midrst_count", 32'(out_count), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_data", 32'(out_data), 32'h00);
      end
    join
    repeat (2 * CPB) @(negedge in_clk);
    check("aborted_frame_no_byte", 32'(out_count), 32'd0);
    exp_q.push_back(8'h03);
    send_frame(8'h03, 1'b1, 1, 1'b0);
    repeat (4) @(negedge in_clk);
    check("post_reset_count", 32'(out_count), 32'd1);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
